// File: rtl/debounce_pio.sv
// debounce_pio: N-channel input conditioner for buttons, switches and slow
// status pins. Each channel is synchronised, polarity-normalised, debounced by
// a stable-count filter and turned into rise/fall/long-press events. Events
// latch into sticky pending flags that combine into one level interrupt.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   in_i     raw asynchronous pin levels
//   state_o  debounced, normalised level (1 = active)
//   rise_o   one-cycle pulse when state_o goes 0->1
//   fall_o   one-cycle pulse when state_o goes 1->0
//   long_o   one-cycle pulse once per press at the long-press threshold
//   ien_i    pending-to-interrupt enable
//   clr_i    pending clear strobe, write-1-to-clear
//   pend_o   sticky pending flags
//   irq_o    |(pend_o & ien_i)
module debounce_pio #(
  parameter int unsigned    N        = 4,
  parameter int unsigned    DEBOUNCE = 327680,
  parameter int unsigned    LONG     = 32768000,
  parameter logic [N-1:0]   INV      = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] state_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] long_o,
  input  logic [N-1:0] ien_i,
  input  logic [N-1:0] clr_i,
  output logic [N-1:0] pend_o,
  output logic         irq_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE);
  localparam int unsigned LW = $clog2(LONG);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);
  localparam logic [LW-1:0] LMAX = LW'(LONG - 1);
  localparam logic [LW-1:0] LPRE = LW'(LONG - 2);

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  norm;
  logic [N-1:0]  state;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [N-1:0]  lng;
  logic [N-1:0]  pend;
  logic [DW-1:0] cnt  [N];
  logic [LW-1:0] hold [N];

  // Synchroniser resets to the idle pin level so norm is 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= INV;
      s2 <= INV;
    end else begin
      s1 <= in_i;
      s2 <= s1;
    end
  end

  assign norm = s2 ^ INV;

  // Accept a change only after DEBOUNCE consecutive differing samples; any
  // agreement with the current state restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (norm[i] == state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DMAX) begin
          state[i] <= norm[i];
          rise[i]  <= norm[i];
          fall[i]  <= ~norm[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Hold counter saturates at LONG-1; long fires on the edge that loads
  // LONG-1, so saturation guarantees a single pulse per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lng <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!state[i]) begin
          hold[i] <= '0;
          lng[i]  <= 1'b0;
        end else begin
          lng[i] <= (hold[i] == LPRE);
          if (hold[i] != LMAX) begin
            hold[i] <= hold[i] + 1'b1;
          end
        end
      end
    end
  end

  // A new event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_i) | rise | fall | lng;
    end
  end

  assign state_o = state;
  assign rise_o  = rise;
  assign fall_o  = fall;
  assign long_o  = lng;
  assign pend_o  = pend;
  assign irq_o   = |(pend & ien_i);

endmodule

// File: tb/tb_debounce_pio.sv
// Self-checking bench for debounce_pio (N=4, DEBOUNCE=8, LONG=32, INV=0011).
// Stimulus tasks push expected events (cycle, pulses, resulting state and
// pending) to a queue; every cycle the queue is drained up to the current
// cycle and all outputs are compared against the expectation.
module tb_debounce_pio;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_i  = 4'b0011;
  logic [3:0] ien_i = 4'b0000;
  logic [3:0] clr_i = 4'b0000;
  logic [3:0] state_o, rise_o, fall_o, long_o, pend_o;
  logic       irq_o;

  debounce_pio #(
    .N(4),
    .DEBOUNCE(8),
    .LONG(32),
    .INV(4'b0011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_i(in_i),
    .state_o(state_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .long_o(long_o),
    .ien_i(ien_i),
    .clr_i(clr_i),
    .pend_o(pend_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int unsigned now = 0;
  always @(posedge clk) now <= now + 1;

  typedef struct {
    int unsigned t;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  lng;
    logic [3:0]  state;
    logic [3:0]  pend;
  } ev_t;

  ev_t         evq[$];
  logic [3:0]  pr = '0, pf = '0, pl = '0, es = '0, ep = '0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned rise_t = 0;

  task automatic push(input int unsigned t, input logic [3:0] r, input logic [3:0] f,
                      input logic [3:0] l, input logic [3:0] s, input logic [3:0] p);
    evq.push_back(ev_t'{t, r, f, l, s, p});
  endtask

  // Wait for the next sample point and load the expectation for this cycle.
  task automatic advance();
    ev_t e;
    @(negedge clk);
    pr = '0;
    pf = '0;
    pl = '0;
    while (evq.size() != 0 && evq[0].t <= now) begin
      e = evq.pop_front();
      if (e.t == now) begin
        pr |= e.rise;
        pf |= e.fall;
        pl |= e.lng;
      end
      es = e.state;
      ep = e.pend;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    in_i  = 4'b0011;
    ien_i = 4'b0000;
    clr_i = 4'b0000;
    for (int k = 1; k <= 104; k++) begin
      advance();
      n_cmp++;
      if ({state_o, rise_o, fall_o, long_o, pend_o, irq_o} !== 21'd0) begin
        n_err++;
        $display("FAIL reset @%0d: got st=%b r=%b f=%b l=%b p=%b irq=%b, want all 0",
                 now, state_o, rise_o, fall_o, long_o, pend_o, irq_o);
      end
      if (k == 4) rst = 1'b0;
    end
  endtask

  task automatic test_glitch();
    ien_i   = 4'b0100;
    in_i[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      advance();
      n_cmp++;
      if ({state_o, rise_o, fall_o, long_o, pend_o, irq_o} !== {es, pr, pf, pl, ep, |(ep & ien_i)}) begin
        n_err++;
        $display("FAIL glitch @%0d: got st=%b r=%b f=%b l=%b p=%b irq=%b, want st=%b r=%b f=%b l=%b p=%b irq=%b",
                 now, state_o, rise_o, fall_o, long_o, pend_o, irq_o, es, pr, pf, pl, ep, |(ep & ien_i));
      end
      if (k == 7) in_i[2] = 1'b0;
    end
  endtask

  task automatic test_press();
    ien_i   = 4'b0001;
    in_i[0] = 1'b0;
    rise_t  = now + 10;
    push(rise_t,     4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    push(rise_t + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    for (int k = 1; k <= 12; k++) begin
      advance();
      n_cmp++;
      if ({state_o, rise_o, fall_o, long_o, pend_o, irq_o} !== {es, pr, pf, pl, ep, |(ep & ien_i)}) begin
        n_err++;
        $display("FAIL press @%0d: got st=%b r=%b f=%b l=%b p=%b irq=%b, want st=%b r=%b f=%b l=%b p=%b irq=%b",
                 now, state_o, rise_o, fall_o, long_o, pend_o, irq_o, es, pr, pf, pl, ep, |(ep & ien_i));
      end
    end
  endtask

  task automatic test_long();
    for (int k = 1; k <= 130; k++) begin
      advance();
      n_cmp++;
      if ({state_o, rise_o, fall_o, long_o, pend_o, irq_o} !== {es, pr, pf, pl, ep, |(ep & ien_i)}) begin
        n_err++;
        $display("FAIL long @%0d: got st=%b r=%b f=%b l=%b p=%b irq=%b, want st=%b r=%b f=%b l=%b p=%b irq=%b",
                 now, state_o, rise_o, fall_o, long_o, pend_o, irq_o, es, pr, pf, pl, ep, |(ep & ien_i));
      end
      case (k)
        1:   push(rise_t + 31, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        40: begin
          in_i[0] = 1'b1;
          push(now + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        end
        55: begin
          clr_i = 4'b0001;
          push(now + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        56:  clr_i = 4'b0000;
        60: begin
          in_i[0] = 1'b0;
          rise_t  = now + 10;
          push(rise_t,      4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
          push(rise_t + 1,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
          push(rise_t + 31, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        end
        110: begin
          in_i[0] = 1'b1;
          push(now + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        end
        125: begin
          clr_i = 4'b0001;
          push(now + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        126: clr_i = 4'b0000;
        default: ;
      endcase
    end
  endtask

  task automatic test_clear_collision();
    ien_i   = 4'b0000;
    in_i[1] = 1'b0;
    push(now + 10, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    push(now + 11, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
    for (int k = 1; k <= 40; k++) begin
      advance();
      n_cmp++;
      if ({state_o, rise_o, fall_o, long_o, pend_o, irq_o} !== {es, pr, pf, pl, ep, 1'b0}) begin
        n_err++;
        $display("FAIL clear_collision @%0d: got st=%b r=%b f=%b l=%b p=%b irq=%b, want st=%b r=%b f=%b l=%b p=%b irq=0",
                 now, state_o, rise_o, fall_o, long_o, pend_o, irq_o, es, pr, pf, pl, ep);
      end
      case (k)
        10: clr_i = 4'b0010;
        11: clr_i = 4'b0000;
        20: begin
          clr_i = 4'b0010;
          push(now + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        end
        21: clr_i = 4'b0000;
        22: begin
          in_i[1] = 1'b1;
          push(now + 10, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
          push(now + 11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        end
        35: begin
          clr_i = 4'b0010;
          push(now + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        36: clr_i = 4'b0000;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid();
    ien_i   = 4'b1000;
    in_i[3] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      advance();
      n_cmp++;
      if ({state_o, rise_o, fall_o, long_o, pend_o, irq_o} !== {es, pr, pf, pl, ep, |(ep & ien_i)}) begin
        n_err++;
        $display("FAIL reset_mid @%0d: got st=%b r=%b f=%b l=%b p=%b irq=%b, want st=%b r=%b f=%b l=%b p=%b irq=%b",
                 now, state_o, rise_o, fall_o, long_o, pend_o, irq_o, es, pr, pf, pl, ep, |(ep & ien_i));
      end
      case (k)
        7:  rst = 1'b1;
        10: begin
          rst = 1'b0;
          push(now + 10, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
          push(now + 11, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_multi();
    ien_i   = 4'b1111;
    in_i[3] = 1'b0;
    in_i[2] = 1'b1;
    push(now + 10, 4'b0100, 4'b1000, 4'b0000, 4'b0100, 4'b1000);
    push(now + 11, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1100);
    for (int k = 1; k <= 30; k++) begin
      advance();
      n_cmp++;
      if ({state_o, rise_o, fall_o, long_o, pend_o, irq_o} !== {es, pr, pf, pl, ep, |(ep & ien_i)}) begin
        n_err++;
        $display("FAIL multi @%0d: got st=%b r=%b f=%b l=%b p=%b irq=%b, want st=%b r=%b f=%b l=%b p=%b irq=%b",
                 now, state_o, rise_o, fall_o, long_o, pend_o, irq_o, es, pr, pf, pl, ep, |(ep & ien_i));
      end
      case (k)
        15: begin
          clr_i = 4'b1100;
          push(now + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        end
        16: begin
          clr_i   = 4'b0000;
          in_i[2] = 1'b0;
          push(now + 10, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
          push(now + 11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        end
        28: begin
          clr_i = 4'b1111;
          push(now + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        29: clr_i = 4'b0000;
        default: ;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_long();
    test_clear_collision();
    test_reset_mid();
    test_multi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
